// File: rtl/reaction_test_controller.sv
// Reaction-timer game sequencer: button edge detect, 1 ms tick, LFSR countdown and early/good/late result.
// Define REACTION_BEST_TIME_EN to add the best-time register and its best/best_valid ports.
module reaction_test_controller #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned INIT_MS      = 1000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter logic [13:0] RAND_MASK    = 14'h07FF,
  parameter int unsigned LATE_MS      = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_p,
  input  logic        stop_p,
  input  logic        clear_p,
  output logic [2:0]  state,
  output logic [13:0] reaction,
`ifdef REACTION_BEST_TIME_EN
  output logic [13:0] best,
  output logic        best_valid,
`endif
  output logic        led
);

  localparam int unsigned CNT_W = 14;
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] ST_START = 3'b000;
  localparam logic [2:0] ST_INIT  = 3'b001;
  localparam logic [2:0] ST_COUNT = 3'b010;
  localparam logic [2:0] ST_TEST  = 3'b011;
  localparam logic [2:0] ST_EARLY = 3'b100;
  localparam logic [2:0] ST_GOOD  = 3'b101;
  localparam logic [2:0] ST_LATE  = 3'b110;

  localparam logic [CNT_W-1:0] INIT_HOLD = CNT_W'(INIT_MS);
  localparam logic [CNT_W-1:0] MIN_DLY   = CNT_W'(MIN_DELAY_MS);
  localparam logic [CNT_W-1:0] LATE_VAL  = CNT_W'(LATE_MS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       btn_sync_q, btn_sync_d;
  logic [2:0]       btn_prev_q, btn_prev_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] reaction_q, reaction_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] reaction_inc;
  logic             tick, start_ev, stop_ev, clear_ev;

`ifdef REACTION_BEST_TIME_EN
  logic [CNT_W-1:0] best_q, best_d;
  logic             best_valid_q, best_valid_d;
`endif

  // Free-running helpers: button sync/edge, ms divider, LFSR
  always_comb begin
    btn_sync_d   = {clear_p, stop_p, start_p};
    btn_prev_d   = btn_sync_q;
    tick         = (div_q == DIV_LAST);
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    start_ev     = btn_sync_q[0] & ~btn_prev_q[0];
    stop_ev      = btn_sync_q[1] & ~btn_prev_q[1];
    clear_ev     = btn_sync_q[2] & ~btn_prev_q[2];
    reaction_inc = reaction_q + CNT_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      div_q      <= '0;
      lfsr_q     <= 16'hACE1;
      hold_q     <= '0;
      delay_q    <= '0;
      reaction_q <= '0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_sync_q <= btn_sync_d;
      btn_prev_q <= btn_prev_d;
      div_q      <= div_d;
      lfsr_q     <= lfsr_d;
      hold_q     <= hold_d;
      delay_q    <= delay_d;
      reaction_q <= reaction_d;
      led_q      <= led_d;
    end
  end

  // Next-state logic; clear overrides everything, 111 falls back to START
  always_comb begin
    state_d = state_q;
    if (clear_ev) begin
      state_d = ST_START;
    end else begin
      unique case (state_q)
        ST_START: if (start_ev) state_d = ST_INIT;
        ST_INIT:  if (tick && hold_q == '0) state_d = ST_COUNT;
        ST_COUNT: begin
          if (stop_ev)                      state_d = ST_EARLY;
          else if (tick && delay_q == '0)   state_d = ST_TEST;
        end
        ST_TEST: begin
          if (stop_ev)                              state_d = ST_GOOD;
          else if (tick && reaction_inc == LATE_VAL) state_d = ST_LATE;
        end
        ST_EARLY, ST_GOOD, ST_LATE: if (start_ev) state_d = ST_INIT;
        default: state_d = ST_START;
      endcase
    end
  end

  // Counters and outputs; stop beats the terminal tick because it is tested first
  always_comb begin
    hold_d     = hold_q;
    delay_d    = delay_q;
    reaction_d = reaction_q;
    led_d      = (state_d == ST_TEST);
    if (clear_ev) begin
      reaction_d = '0;
    end else begin
      unique case (state_q)
        ST_START: if (start_ev) hold_d = INIT_HOLD;
        ST_INIT: begin
          if (tick) begin
            if (hold_q == '0) delay_d = MIN_DLY + (lfsr_q[13:0] & RAND_MASK);
            else              hold_d  = hold_q - CNT_W'(1);
          end
        end
        ST_COUNT: begin
          if (stop_ev) begin
            reaction_d = '0;
          end else if (tick) begin
            if (delay_q == '0) reaction_d = '0;
            else               delay_d    = delay_q - CNT_W'(1);
          end
        end
        ST_TEST: if (!stop_ev && tick) reaction_d = reaction_inc;
        ST_EARLY, ST_GOOD, ST_LATE: begin
          if (start_ev) begin
            hold_d     = INIT_HOLD;
            reaction_d = '0;
          end
        end
        default: reaction_d = '0;
      endcase
    end
  end

`ifdef REACTION_BEST_TIME_EN
  // Best time only updates on TEST->GOOD and survives clear
  always_comb begin
    best_d       = best_q;
    best_valid_d = best_valid_q;
    if (state_q == ST_TEST && state_d == ST_GOOD &&
        (!best_valid_q || reaction_q < best_q)) begin
      best_d       = reaction_q;
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q       <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign best       = best_q;
  assign best_valid = best_valid_q;
`endif

  assign state    = state_q;
  assign reaction = reaction_q;
  assign led      = led_q;

endmodule

// File: tb/tb_reaction_test_controller.sv
// Directed bench for reaction_test_controller with scaled timing (4 clk per ms tick).
// Best-time checks compile in when REACTION_BEST_TIME_EN is defined.
module tb_reaction_test_controller;

  localparam logic [2:0] ST_START = 3'b000;
  localparam logic [2:0] ST_INIT  = 3'b001;
  localparam logic [2:0] ST_COUNT = 3'b010;
  localparam logic [2:0] ST_TEST  = 3'b011;
  localparam logic [2:0] ST_EARLY = 3'b100;
  localparam logic [2:0] ST_GOOD  = 3'b101;
  localparam logic [2:0] ST_LATE  = 3'b110;

  localparam int BTN_START = 1;
  localparam int BTN_STOP  = 2;
  localparam int BTN_CLEAR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_p, stop_p, clear_p;
  logic [2:0]  state;
  logic [13:0] reaction;
  logic        led;
`ifdef REACTION_BEST_TIME_EN
  logic [13:0] best;
  logic        best_valid;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  int led_hi_cnt = 0;

  typedef struct {
    int         stop_at;   // -1: never press stop
    logic [2:0] exp_state;
    int         exp_rx;
    int         exp_best;
  } vec_t;
  vec_t vecs[5];

  reaction_test_controller #(
    .TICK_DIV(4), .INIT_MS(3), .MIN_DELAY_MS(5), .RAND_MASK(14'h0000), .LATE_MS(20)
  ) dut (
    .clk(clk), .rst(rst),
    .start_p(start_p), .stop_p(stop_p), .clear_p(clear_p),
    .state(state), .reaction(reaction),
`ifdef REACTION_BEST_TIME_EN
    .best(best), .best_valid(best_valid),
`endif
    .led(led)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; the DUT divider wraps on edges where this is a multiple of 4
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) if (led) led_hi_cnt <= led_hi_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int mask, input int cycles);
    start_p = mask[0];
    stop_p  = mask[1];
    clear_p = mask[2];
    step(cycles);
    start_p = 1'b0;
    stop_p  = 1'b0;
    clear_p = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output int edge_at);
    edge_at = -1;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (state == target) begin
        edge_at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_state timeout: state %0d required %0d", state, target);
  endtask

  task automatic wait_reaction(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (reaction == 14'(n)) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_reaction timeout: reaction %0d required %0d", reaction, n);
  endtask

  task automatic run_to_test();
    int e;
    press(BTN_CLEAR, 2);
    press(BTN_START, 2);
    wait_state(ST_TEST, 200, e);
  endtask

  function automatic int nth_tick_after(input int e, input int k);
    int n = e;
    int c = 0;
    while (c < k) begin
      n++;
      if (n % 4 == 0) c++;
    end
    return n;
  endfunction

  initial begin
    int e_init, e_cd, e_test, led_before;
    vecs[0] = '{9,  ST_GOOD, 9,  9};
    vecs[1] = '{5,  ST_GOOD, 5,  5};
    vecs[2] = '{12, ST_GOOD, 12, 5};
    vecs[3] = '{-1, ST_LATE, 20, 5};
    vecs[4] = '{7,  ST_GOOD, 7,  5};

    rst = 1'b1; start_p = 1'b0; stop_p = 1'b0; clear_p = 1'b0;
    step(3);
    chk("rst_state", state, ST_START);
    chk("rst_reaction", reaction, 0);
    chk("rst_led", led, 0);
    @(negedge clk) rst = 1'b0;
    step(1);

    // Start latency and INIT/COUNTDOWN durations measured in tick edges
    start_p = 1'b1;
    step(1);
    chk("start_lat_1clk", state, ST_START);
    step(1);
    chk("start_lat_2clk", state, ST_INIT);
    e_init = cyc;
    start_p = 1'b0;
    wait_state(ST_COUNT, 100, e_cd);
    chk("init_to_cd_edge", e_cd, nth_tick_after(e_init, 4));
    chk("cd_led", led, 0);
    wait_state(ST_TEST, 100, e_test);
    chk("cd_to_test_edge", e_test, nth_tick_after(e_cd, 6));
    chk("test_led", led, 1);
    chk("test_reaction0", reaction, 0);

    // Table of TEST-phase runs
    foreach (vecs[i]) begin
      run_to_test();
      if (vecs[i].stop_at >= 0) begin
        wait_reaction(vecs[i].stop_at, 200);
        press(BTN_STOP, 2);
      end else begin
        wait_state(ST_LATE, 200, e_test);
      end
      chk($sformatf("v%0d_state", i), state, vecs[i].exp_state);
      chk($sformatf("v%0d_reaction", i), reaction, vecs[i].exp_rx);
      chk($sformatf("v%0d_led", i), led, 0);
      if (vecs[i].exp_state == ST_GOOD) begin
        step(100);
        chk($sformatf("v%0d_hold", i), reaction, vecs[i].exp_rx);
      end
`ifdef REACTION_BEST_TIME_EN
      chk($sformatf("v%0d_best", i), best, vecs[i].exp_best);
      chk($sformatf("v%0d_best_valid", i), best_valid, 1);
`endif
      press(BTN_CLEAR, 2);
      chk($sformatf("v%0d_clear_state", i), state, ST_START);
      chk($sformatf("v%0d_clear_reaction", i), reaction, 0);
    end

    // Stop during COUNTDOWN: EARLY, LED never lit, stop then ignored, start restarts
    press(BTN_START, 2);
    wait_state(ST_COUNT, 100, e_cd);
    led_before = led_hi_cnt;
    press(BTN_STOP, 2);
    step(2);
    chk("early_state", state, ST_EARLY);
    chk("early_reaction", reaction, 0);
    chk("early_led_count", led_hi_cnt - led_before, 0);
    press(BTN_STOP, 2);
    step(2);
    chk("early_stop_ignored", state, ST_EARLY);
`ifdef REACTION_BEST_TIME_EN
    chk("early_best", best, 5);
    chk("early_best_valid", best_valid, 1);
`endif
    press(BTN_START, 2);
    chk("early_restart_state", state, ST_INIT);
    chk("early_restart_reaction", reaction, 0);

    // Stop lands in the same cycle as the terminal tick
    run_to_test();
    wait_reaction(19, 200);
    step(2);
    press(BTN_STOP, 2);
    chk("term_tie_state", state, ST_GOOD);
    chk("term_tie_reaction", reaction, 19);
    chk("term_tie_led", led, 0);

    // Clear, start and stop together in TEST
    run_to_test();
    wait_reaction(3, 100);
    press(BTN_START | BTN_STOP | BTN_CLEAR, 2);
    chk("all_btn_state", state, ST_START);
    chk("all_btn_reaction", reaction, 0);
    chk("all_btn_led", led, 0);

    // Asynchronous reset in the middle of TEST
    run_to_test();
    wait_reaction(4, 100);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_state", state, ST_START);
    chk("async_rst_reaction", reaction, 0);
    chk("async_rst_led", led, 0);
`ifdef REACTION_BEST_TIME_EN
    chk("async_rst_best", best, 0);
    chk("async_rst_best_valid", best_valid, 0);
`endif
    @(negedge clk) rst = 1'b0;
    step(2);
    chk("post_rst_state", state, ST_START);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
